// File: rtl/shr_loader.sv
// Serializes a parallel word, LSB first, into a downstream right-shift register
// whose serial input enters at the MSB; also issues a one-cycle clear on request.
module shr_loader #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] din,
    input  logic         clr_req,
    output logic         r,
    output logic [1:0]   opr,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCount = CW'(N - 1);

    localparam logic [1:0] OpShift = 2'd0;
    localparam logic [1:0] OpHold  = 2'd1;
    localparam logic [1:0] OpClear = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StShift,
        StDone
    } state_e;

    state_e        r_state;
    logic [N-1:0]  r_shadow;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_shadow <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Clear wins over start; a start arriving with clr_req is dropped.
                    if (clr_req) begin
                        r_state <= StClear;
                    end else if (start) begin
                        r_shadow <= din;
                        r_count  <= '0;
                        r_state  <= StShift;
                    end
                end
                StClear: r_state <= StIdle;
                StShift: begin
                    r_shadow <= r_shadow >> 1;
                    // Hold the count on the last shift so it never wraps.
                    if (r_count == LastCount) begin
                        r_state <= StDone;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        opr  = OpHold;
        r    = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (r_state)
            StIdle:  busy = 1'b0;
            StClear: opr  = OpClear;
            StShift: begin
                opr = OpShift;
                r   = r_shadow[0];
            end
            StDone:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_shr_loader.sv
// Self-checking bench for shr_loader: a fixed vector table for the directed corner
// cases, then random traffic checked against a transaction-queue reference model.
module tb_shr_loader;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] din;
    logic         clr_req;
    logic         r;
    logic [1:0]   opr;
    logic         busy;
    logic         done;

    shr_loader #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .clr_req (clr_req),
        .r       (r),
        .opr     (opr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Downstream right-shift register, driven only by the DUT outputs.
    logic [N-1:0] q_down = '0;
    always @(posedge clk) begin
        case (opr)
            2'd0: q_down <= {r, q_down[N-1:1]};
            2'd2: q_down <= '0;
            default: q_down <= q_down;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each entry is one busy cycle's expected {opr, r, done}.
    logic [3:0]   exp_q[$];
    logic [N-1:0] m_down = '0;

    task automatic cycle(input logic t_rst, input logic t_start, input logic t_clr,
                         input logic [N-1:0] t_din,
                         output logic [1:0] a_opr, output logic a_r,
                         output logic a_busy, output logic a_done);
        logic [3:0] e;
        logic       e_busy;
        rst     = t_rst;
        start   = t_start;
        clr_req = t_clr;
        din     = t_din;
        @(negedge clk);
        a_opr  = opr;
        a_r    = r;
        a_busy = busy;
        a_done = done;
        e_busy = (exp_q.size() > 0);
        e      = e_busy ? exp_q[0] : {2'd1, 1'b0, 1'b0};
        n_checks++;
        if ({a_opr, a_r, a_done, a_busy} !== {e, e_busy}) begin
            n_errors++;
            $display("FAIL model_outputs t=%0t got opr=%0d r=%b busy=%b done=%b want opr=%0d r=%b busy=%b done=%b",
                     $time, a_opr, a_r, a_busy, a_done, e[3:2], e[1], e_busy, e[0]);
        end
        n_checks++;
        if (q_down !== m_down) begin
            n_errors++;
            $display("FAIL downstream_q t=%0t got %b want %b", $time, q_down, m_down);
        end
        @(posedge clk);
        if (e[3:2] == 2'd0)      m_down = {e[1], m_down[N-1:1]};
        else if (e[3:2] == 2'd2) m_down = '0;
        if (t_rst) begin
            exp_q.delete();
        end else if (e_busy) begin
            void'(exp_q.pop_front());
        end else if (t_clr) begin
            exp_q.push_back({2'd2, 1'b0, 1'b0});
        end else if (t_start) begin
            for (int i = 0; i < int'(N); i++) exp_q.push_back({2'd0, t_din[i], 1'b0});
            exp_q.push_back({2'd1, 1'b0, 1'b1});
        end
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic         start;
        logic         clr;
        logic [N-1:0] din;
        logic [1:0]   opr;
        logic         r;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[26];

    initial begin
        logic [1:0] a_opr;
        logic       a_r, a_busy, a_done;

        // Full word, starts in SHIFT and DONE ignored, back-to-back start, din churn.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'b1011, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b1001, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1};
        // start and clr_req together: clear only; start during CLEAR ignored.
        tbl[12] = '{1'b0, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        // Reset in SHIFT cycle 2 aborts; then a fresh word 0110.
        tbl[15] = '{1'b0, 1'b1, 1'b0, 4'b1011, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 4'b0110, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        clr_req = 1'b0;
        din     = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].rst, tbl[i].start, tbl[i].clr, tbl[i].din,
                  a_opr, a_r, a_busy, a_done);
            n_checks++;
            if ({a_opr, a_r, a_busy, a_done} !==
                {tbl[i].opr, tbl[i].r, tbl[i].busy, tbl[i].done}) begin
                n_errors++;
                $display("FAIL vector_%0d got opr=%0d r=%b busy=%b done=%b want opr=%0d r=%b busy=%b done=%b",
                         i, a_opr, a_r, a_busy, a_done,
                         tbl[i].opr, tbl[i].r, tbl[i].busy, tbl[i].done);
            end
        end

        // Word sent at vectors 19-24 must now sit in the downstream register.
        n_checks++;
        if (q_down !== 4'b0110) begin
            n_errors++;
            $display("FAIL final_word got %b want 0110", q_down);
        end

        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), N'($urandom), a_opr, a_r, a_busy, a_done);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
